aire_ctrl_param: RTL and testbench

Parametrised air-conditioner controller: a supervisory on/check/run/fault state machine, per-button counter-based debouncers, and saturating or wrapping setting registers for fan speed, temperature setpoint and mode. It sits at the top of the climate-control design and drives the status LEDs and the LCD/mode display fields. Speed levels, temperature range, mode count and debounce/check timing are all parameters.

---
 rtl/aire_ctrl_param.sv | 179 +++++++++++++++++
 tb/tb_aire_ctrl_param.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aire_ctrl_param.sv
// Air-conditioner supervisor: an on/check/run/fault state machine, per-button debouncers,
// and fan-speed/setpoint/mode setting registers. The outputs are zeroed outside RUN.
module aire_ctrl_param #(
  parameter int unsigned N_VEL     = 4,
  parameter int unsigned N_TEMP    = 8,
  parameter int unsigned TEMP_INIT = 3,
  parameter int unsigned N_MODE    = 3,
  parameter int unsigned DEB_CYC   = 4,
  parameter int unsigned CHK_CYC   = 2,
  parameter int unsigned CHK_TO    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      on,
  input  logic                      pb_vel_up,
  input  logic                      pb_vel_dn,
  input  logic                      pb_tmp_up,
  input  logic                      pb_tmp_dn,
  input  logic                      pb_mode,
  input  logic [2:0]                ok,
  output logic [1:0]                state,
  output logic [$clog2(N_VEL)-1:0]  vel,
  output logic [$clog2(N_TEMP)-1:0] temp,
  output logic [$clog2(N_MODE)-1:0] mode,
  output logic                      disp_en
);

  localparam int unsigned VW = $clog2(N_VEL);
  localparam int unsigned TW = $clog2(N_TEMP);
  localparam int unsigned MW = $clog2(N_MODE);
  localparam int unsigned DW = $clog2(DEB_CYC + 1);
  localparam int unsigned GW = $clog2(CHK_CYC + 1);
  localparam int unsigned CW = $clog2(CHK_TO + 1);
  localparam int unsigned NB = 5;

  // Bit positions of the buttons inside the packed debouncer vectors
  localparam int unsigned BVelUp = 4;
  localparam int unsigned BVelDn = 3;
  localparam int unsigned BTmpUp = 2;
  localparam int unsigned BTmpDn = 1;
  localparam int unsigned BMode  = 0;

  typedef enum logic [1:0] {
    StOff   = 2'b00,
    StCheck = 2'b01,
    StFault = 2'b10,
    StRun   = 2'b11
  } state_e;

  state_e st_q, st_d;
  logic [GW-1:0] good_q, good_d;
  logic [CW-1:0] chk_q, chk_d;

  logic [NB-1:0] raw;
  logic [NB-1:0] lvl_q, lvl_d;
  logic [NB-1:0] pls_q, pls_d;
  logic [DW-1:0] dcnt_q [NB];
  logic [DW-1:0] dcnt_d [NB];

  logic [VW-1:0] vel_q, vel_d;
  logic [TW-1:0] temp_q, temp_d;
  logic [MW-1:0] mode_q, mode_d;
  logic          run;

  assign raw = {pb_vel_up, pb_vel_dn, pb_tmp_up, pb_tmp_dn, pb_mode};

  // Debouncers: a level change is accepted after DEB_CYC consecutive differing samples
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      lvl_d[i]  = lvl_q[i];
      pls_d[i]  = 1'b0;
      dcnt_d[i] = '0;
      if (raw[i] != lvl_q[i]) begin
        if (dcnt_q[i] == DW'(DEB_CYC - 1)) begin
          lvl_d[i] = raw[i];
          pls_d[i] = raw[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lvl_q <= '0;
      pls_q <= '0;
      for (int i = 0; i < NB; i++) dcnt_q[i] <= '0;
    end else begin
      lvl_q <= lvl_d;
      pls_q <= pls_d;
      for (int i = 0; i < NB; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  // Supervisor; check counters only count while in CHECK and are zero on entry
  always_comb begin
    st_d   = st_q;
    good_d = '0;
    chk_d  = '0;
    if (!on) begin
      st_d = StOff;
    end else begin
      unique case (st_q)
        StOff: st_d = StCheck;
        StCheck: begin
          good_d = (ok == 3'b111) ? good_q + GW'(1) : '0;
          chk_d  = chk_q + CW'(1);
          if (good_d == GW'(CHK_CYC)) begin
            st_d = StRun;
          end else if (chk_d == CW'(CHK_TO)) begin
            st_d = StFault;
          end
        end
        StRun: begin
          if (ok != 3'b111) st_d = StFault;
        end
        StFault: st_d = StFault;
        default: st_d = StOff;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q   <= StOff;
      good_q <= '0;
      chk_q  <= '0;
    end else begin
      st_q   <= st_d;
      good_q <= good_d;
      chk_q  <= chk_d;
    end
  end

  // Settings follow the current state, so a pulse on the edge that leaves RUN still lands
  always_comb begin
    vel_d  = vel_q;
    temp_d = temp_q;
    mode_d = mode_q;
    if (st_q == StRun) begin
      if (pls_q[BVelUp] && !pls_q[BVelDn] && (vel_q != VW'(N_VEL - 1))) begin
        vel_d = vel_q + VW'(1);
      end else if (pls_q[BVelDn] && !pls_q[BVelUp] && (vel_q != '0)) begin
        vel_d = vel_q - VW'(1);
      end
      if (pls_q[BTmpUp] && !pls_q[BTmpDn] && (temp_q != TW'(N_TEMP - 1))) begin
        temp_d = temp_q + TW'(1);
      end else if (pls_q[BTmpDn] && !pls_q[BTmpUp] && (temp_q != '0)) begin
        temp_d = temp_q - TW'(1);
      end
      if (pls_q[BMode]) begin
        mode_d = (mode_q == MW'(N_MODE - 1)) ? '0 : mode_q + MW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vel_q  <= '0;
      temp_q <= TW'(TEMP_INIT);
      mode_q <= '0;
    end else begin
      vel_q  <= vel_d;
      temp_q <= temp_d;
      mode_q <= mode_d;
    end
  end

  always_comb begin
    run     = (st_q == StRun);
    state   = st_q;
    disp_en = run;
    vel     = run ? vel_q  : '0;
    temp    = run ? temp_q : '0;
    mode    = run ? mode_q : '0;
  end

endmodule

// File: tb/tb_aire_ctrl_param.sv
// Scoreboard bench for aire_ctrl_param: stimulus queues the expected output snapshot and edge,
// a negedge monitor pops and compares whenever the visible outputs change.
module tb_aire_ctrl_param;

  localparam int DEB = 4;
  localparam int VW  = 2;
  localparam int TW  = 3;
  localparam int MW  = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          on    = 1'b0;
  logic [4:0]    pb    = '0;  // {vel_up, vel_dn, tmp_up, tmp_dn, mode}
  logic [2:0]    ok    = '0;
  logic [1:0]    state;
  logic [VW-1:0] vel;
  logic [TW-1:0] temp;
  logic [MW-1:0] mode;
  logic          disp_en;

  aire_ctrl_param #(
    .N_VEL(4), .N_TEMP(8), .TEMP_INIT(3), .N_MODE(3), .DEB_CYC(DEB), .CHK_CYC(2), .CHK_TO(16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .on        (on),
    .pb_vel_up (pb[4]),
    .pb_vel_dn (pb[3]),
    .pb_tmp_up (pb[2]),
    .pb_tmp_dn (pb[1]),
    .pb_mode   (pb[0]),
    .ok        (ok),
    .state     (state),
    .vel       (vel),
    .temp      (temp),
    .mode      (mode),
    .disp_en   (disp_en)
  );

  always #5 clock = ~clock;

  int edge_n = 0;
  always @(posedge clock) edge_n++;

  typedef struct packed {
    logic [1:0]    st;
    logic [VW-1:0] v;
    logic [TW-1:0] t;
    logic [MW-1:0] m;
    logic          en;
  } snap_t;

  typedef struct {
    int    e;
    snap_t s;
  } exp_t;

  exp_t  q[$];
  snap_t prev;
  bit    mon_en = 1'b0;
  int    n_cmp  = 0;
  int    n_bad  = 0;
  int    cv, ct, cm;

  int vtab[5] = '{1, 2, 3, 3, 3};
  int mtab[4] = '{1, 2, 0, 1};

  function automatic snap_t snap();
    snap_t s;
    s.st = state; s.v = vel; s.t = temp; s.m = mode; s.en = disp_en;
    return s;
  endfunction

  function automatic snap_t mk(logic [1:0] st, int v, int t, int m);
    snap_t s;
    s.st = st; s.v = VW'(v); s.t = TW'(t); s.m = MW'(m); s.en = (st == 2'b11);
    return s;
  endfunction

  task automatic report(string nm, snap_t g, int ge, snap_t w, int we);
    n_bad++;
    $display("FAIL %s: got st=%b vel=%0d temp=%0d mode=%0d en=%b @edge %0d, want st=%b vel=%0d temp=%0d mode=%0d en=%b @edge %0d",
             nm, g.st, g.v, g.t, g.m, g.en, ge, w.st, w.v, w.t, w.m, w.en, we);
  endtask

  task automatic check_now(string nm, snap_t w);
    snap_t g;
    g = snap();
    n_cmp++;
    if (g !== w) report(nm, g, edge_n, w, edge_n);
  endtask

  task automatic exp_st(int de, logic [1:0] st);
    q.push_back('{e: edge_n + de, s: mk(st, 0, 0, 0)});
  endtask

  task automatic exp_run(int de, int v, int t, int m);
    q.push_back('{e: edge_n + de, s: mk(2'b11, v, t, m)});
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(logic [4:0] mask, int len);
    pb = mask;
    step(len);
    pb = '0;
    step(DEB + 2);
  endtask

  // Monitor: every visible output change must match the next queued expectation
  always @(negedge clock) begin
    if (mon_en) begin
      snap_t cur;
      exp_t  x;
      cur = snap();
      if (cur !== prev) begin
        n_cmp++;
        if (q.size() == 0) begin
          report("unexpected_change", cur, edge_n, prev, edge_n);
        end else begin
          x = q.pop_front();
          if (cur !== x.s || edge_n != x.e) report("output_event", cur, edge_n, x.s, x.e);
        end
        prev = cur;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(3);
    reset = 1'b0;
    step(1);
    check_now("reset_state", mk(2'b00, 0, 0, 0));
    prev   = snap();
    mon_en = 1'b1;

    // Power up: CHECK one edge later, RUN two edges after that
    cv = 0; ct = 3; cm = 0;
    exp_st(1, 2'b01);
    exp_run(3, cv, ct, cm);
    on = 1'b1; ok = 3'b111;
    step(4);

    // Fan speed up x5 saturates at 3, then a short glitch does nothing
    for (int i = 0; i < 5; i++) begin
      if (vtab[i] != cv) begin
        cv = vtab[i];
        exp_run(DEB + 1, cv, ct, cm);
      end
      press(5'b10000, DEB);
    end
    press(5'b10000, DEB - 1);
    check_now("glitch_no_change", mk(2'b11, 3, 3, 0));

    cv = 2;
    exp_run(DEB + 1, cv, ct, cm);
    press(5'b01000, DEB);

    for (int i = 0; i < 4; i++) begin
      cm = mtab[i];
      exp_run(DEB + 1, cv, ct, cm);
      press(5'b00001, DEB);
    end

    // Simultaneous up/down cancels; single presses move the setpoint
    press(5'b00110, DEB);
    ct = 4;
    exp_run(DEB + 1, cv, ct, cm);
    press(5'b00100, DEB);
    ct = 3;
    exp_run(DEB + 1, cv, ct, cm);
    press(5'b00010, DEB);

    // One-cycle fan fault in RUN latches FAULT
    exp_st(1, 2'b10);
    ok = 3'b110;
    step(1);
    ok = 3'b111;
    step(4);
    check_now("fault_hold", mk(2'b10, 0, 0, 0));
    exp_st(1, 2'b00);
    on = 1'b0;
    step(3);
    exp_st(1, 2'b01);
    exp_run(3, cv, ct, cm);
    on = 1'b1;
    step(5);

    // Pulse landing on the same edge as on=0 still updates the speed
    pb = 5'b01000;
    step(DEB);
    exp_st(1, 2'b00);
    on = 1'b0; pb = '0;
    step(DEB + 3);
    cv = 1;
    exp_st(1, 2'b01);
    exp_run(3, cv, ct, cm);
    on = 1'b1;
    step(5);

    // CHECK timeout with sensor flag low
    exp_st(1, 2'b00);
    on = 1'b0;
    step(2);
    exp_st(1, 2'b01);
    exp_st(17, 2'b10);
    ok = 3'b101; on = 1'b1;
    step(20);
    ok = 3'b111;
    step(5);
    check_now("fault_no_retry", mk(2'b10, 0, 0, 0));
    exp_st(1, 2'b00);
    on = 1'b0;
    step(2);
    exp_st(1, 2'b01);
    exp_run(3, cv, ct, cm);
    on = 1'b1;
    step(5);

    // Presses in OFF and CHECK are discarded
    exp_st(1, 2'b00);
    on = 1'b0;
    step(2);
    press(5'b00100, DEB);
    exp_st(1, 2'b01);
    ok = 3'b101; on = 1'b1;
    step(1);
    press(5'b00100, DEB);
    exp_run(2, cv, ct, cm);
    ok = 3'b111;
    step(4);

    // Reset mid-debounce restores reset values and fires no pulse
    pb = 5'b10000;
    step(2);
    exp_st(1, 2'b00);
    reset = 1'b1; pb = '0;
    step(2);
    cv = 0; ct = 3; cm = 0;
    exp_st(1, 2'b01);
    exp_run(3, cv, ct, cm);
    reset = 1'b0;
    step(DEB + 4);
    check_now("post_reset_run", mk(2'b11, 0, 3, 0));

    step(3);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending expectations, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
